// File: rtl/interval_timer_if.sv
// Command/event bundle between the traffic-light controller and its interval timer.
// The controller holds the master side; the timer holds the slave side.
interface interval_timer_if #(
  parameter int CW = 8
);
  logic          EN;
  logic          en_IC;
  logic [1:0]    s_IC;
  logic          rcos;
  logic          rcol;
  logic          busy;
  logic [CW-1:0] count;

  modport master (
    output EN, en_IC, s_IC,
    input  rcos, rcol, busy, count
  );

  modport slave (
    input  EN, en_IC, s_IC,
    output rcos, rcol, busy, count
  );
endinterface

// File: rtl/interval_timer.sv
// Prescaled short/long interval timer; pulses rcos/rcol for one cycle on expiry.
// Commands win over a coincident expiry; EN=0 freezes prescaler and count.
module interval_timer #(
  parameter int PRESCALE    = 10,
  parameter int SHORT_TICKS = 5,
  parameter int LONG_TICKS  = 25,
  parameter int CW          = 8
) (
  input  logic             clk,
  input  logic             R,
  interval_timer_if.slave  bus
);
  localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [1:0]      IDLE    = 2'd0;
  localparam logic [1:0]      RUN_S   = 2'd1;
  localparam logic [1:0]      RUN_L   = 2'd2;

  logic [1:0]    r_state;
  logic [PW-1:0] r_pre;
  logic [CW-1:0] r_count;
  logic          r_rcos;
  logic          r_rcol;

  logic w_cmd, w_run, w_step, w_tick, w_last;

  assign w_cmd  = bus.en_IC && (bus.s_IC != 2'b00);
  assign w_run  = (r_state != IDLE);
  assign w_step = w_run && bus.EN;
  assign w_tick = w_step && (r_pre == PRE_MAX);
  assign w_last = w_tick && (r_count == CW'(1));

  always_ff @(posedge clk) begin
    if (R) begin
      r_state <= IDLE;
      r_pre   <= '0;
      r_count <= '0;
      r_rcos  <= 1'b0;
      r_rcol  <= 1'b0;
    end else begin
      r_rcos <= 1'b0;
      r_rcol <= 1'b0;
      if (w_cmd) begin
        // a command always restarts the prescaler and suppresses any expiry pulse
        r_pre <= '0;
        case (bus.s_IC)
          2'b01: begin
            r_state <= RUN_S;
            r_count <= CW'(SHORT_TICKS);
          end
          2'b10: begin
            r_state <= RUN_L;
            r_count <= CW'(LONG_TICKS);
          end
          default: begin
            r_state <= IDLE;
            r_count <= '0;
          end
        endcase
      end else if (w_tick) begin
        r_pre <= '0;
        if (r_count != '0) r_count <= r_count - 1'b1;
        if (w_last) begin
          r_state <= IDLE;
          r_rcos  <= (r_state == RUN_S);
          r_rcol  <= (r_state == RUN_L);
        end
      end else if (w_step) begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  assign bus.rcos  = r_rcos;
  assign bus.rcol  = r_rcol;
  assign bus.busy  = w_run;
  assign bus.count = r_count;
endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Programmable interval timer that feeds the traffic-light controller its "short interval done" (rcos) and "long interval done" (rcol) events.
- The controller's interval command (s_IC plus strobe en_IC) selects and starts either a short (yellow) or a long (green) interval.
- A clock prescaler turns clk into timer ticks; the global EN pauses timing.
- Sits directly beside the controller FSM; its outputs are the controller's counter inputs.

Parameters:
- PRESCALE, 10: clk cycles per timer tick; must be >= 1; 1 means one tick per clk.
- SHORT_TICKS, 5: ticks in a short interval; must be >= 1.
- LONG_TICKS, 25: ticks in a long interval; must be >= SHORT_TICKS.
- CW, 8: width of the tick counter; both SHORT_TICKS and LONG_TICKS must fit in CW bits.

Ports:
- clk  in  1  system clock, rising edge.
- R  in  1  reset, synchronous, active-high.
- EN  in  1  global enable; 0 freezes the prescaler and tick counter.
- en_IC  in  1  command strobe; s_IC is sampled only when en_IC=1.
- s_IC  in  2  command: 00 no-op, 01 start short, 10 start long, 11 abort.
- rcos  out  1  one-cycle pulse when a short interval expires.
- rcol  out  1  one-cycle pulse when a long interval expires.
- busy  out  1  1 while an interval is running (state != IDLE).
- count  out  CW  remaining ticks in the current interval; 0 when idle.

Behaviour:
- Single clock domain.
- Reset: synchronous, active-high; all outputs are registered.
  - When R=1 at an edge: state=IDLE, count=0, prescaler=0, rcos=0, rcol=0, busy=0.
  - R overrides en_IC and EN in the same cycle.
  - Reset mid-interval aborts the interval with no pulse.
- States: IDLE, RUN_S, RUN_L.
- Commands (en_IC=1), accepted in any state and regardless of EN:
  - 01: count<=SHORT_TICKS, prescaler<=0, state<=RUN_S.
  - 10: count<=LONG_TICKS, prescaler<=0, state<=RUN_L.
  - 11: count<=0, prescaler<=0, state<=IDLE; no pulse.
  - 00: ignored.
- Retrigger: a start command while running restarts from full value and discards the old interval.
- Counting in RUN_S or RUN_L, only when EN=1:
  - prescaler increments each clk.
  - When prescaler==PRESCALE-1: prescaler<=0 and count<=count-1 (this is one tick).
- Expiry: a tick with count==1 sets count<=0 and state<=IDLE.
  - On the same edge, rcos<=1 (from RUN_S) or rcol<=1 (from RUN_L).
  - The pulse lasts exactly one cycle; rcos and rcol are never high together.
- Latency with EN held at 1:
  - Pulse is high in the cycle following edge N*PRESCALE after the load edge, where N = SHORT_TICKS or LONG_TICKS.
  - busy falls on that same edge.
- EN=0: prescaler and count hold; no tick, no pulse. Resuming with EN=1 continues from the held values.
- Simultaneous command and expiry: the command wins and no pulse is generated. A command with s_IC=00 does not block the expiry.
- IDLE: prescaler is held at 0; rcos/rcol are 0 except in the single cycle after expiry.
- Width: count never underflows.
  - A tick in IDLE is impossible.
  - The decrement happens only when count >= 1.

Test Plan (PRESCALE=2, SHORT_TICKS=3, LONG_TICKS=6, CW=8):
- Reset: hold R=1 for 2 cycles with en_IC=1, s_IC=01 -> after release, busy=0, count=0, rcos=rcol=0; the command is ignored.
- Short interval: strobe 01 at edge 0, EN=1 -> count reads 3,3,2,2,1,1; rcos=1 only in the cycle after edge 6; busy=0 from then; rcol stays 0.
- Long interval with pause: strobe 10, EN=0 for 5 cycles mid-run -> rcol pulse delayed by exactly 5 cycles (edge 17 instead of 12); count frozen during the pause.
- Retrigger: start short, then at count==1 strobe 10 -> count=6, state long, no rcos; rcol fires 12 cycles after the retrigger.
- Abort vs expiry: strobe 11 in the same cycle the final tick would occur -> no rcos; busy=0, count=0.
- Back-to-back: strobe 01 in the cycle rcos is high -> new short interval starts; the next rcos follows 6 cycles later, with no missed or duplicate pulses.
